frame_pixel_reader: RTL and testbench
=====================================

# frame_pixel_reader

Pixel-clock-domain reader between the dual-clock frame RAM (32-bit words, four 8-bit grey pixels each) and the HDMI transmitter. It generates the RAM read addresses for one frame and prefetches words ahead of the display. Each word is unpacked LSB-byte-first into one grey pixel per display-enable cycle. It also flags frames where the display timing and the RAM contents disagree.

## Interface
Parameters:
- WIDTH, 640, active pixels per line; must be a multiple of 4.
- HEIGHT, 480, active lines per frame.
- ADDR_W, 17, RAM word-address width.
- BASE_ADDR, 0, word address of pixel (0,0).

Ports:
- pixclk  in  1  pixel clock; the only clock.
- reset  in  1  asynchronous, active-low reset.
- frame_start  in  1  one-cycle pulse during vertical blanking that starts a frame.
- de  in  1  display enable: one pixel is requested per high cycle.
- pattern_en  in  1  when 1, output the test pattern instead of RAM data. Sampled each de cycle.
- ram_addr  out  ADDR_W  registered word read address to the RAM port B.
- ram_data  in  32  RAM read data; valid the cycle after the RAM clocks ram_addr (registered read).
- grey  out  8  pixel value.
- grey_valid  out  1  de delayed by one cycle.
- frame_done  out  1  one-cycle pulse after the last pixel of the frame is output.
- underrun  out  1  sticky: de arrived before the prefetch completed.
- overrun  out  1  sticky: more than WIDTH*HEIGHT de cycles occurred in a frame.

## Operation
- State machine: IDLE -> PREFETCH -> ACTIVE -> DONE.
- IDLE (after reset):
  - de produces grey=0 with grey_valid=1.
  - frame_start moves to PREFETCH.
- PREFETCH:
  - Lasts exactly 4 cycles.
  - Cycle 0: ram_addr=BASE_ADDR.
  - Cycle 1: ram_addr=BASE_ADDR+1.
  - Cycle 2: ram_data (word BASE_ADDR) is loaded into the shift register.
  - Cycle 3: ram_data (word BASE_ADDR+1) is loaded into the next-word register.
  - Then enter ACTIVE.
- ACTIVE, on each de cycle:
  - Output the current shift-register byte, in order [7:0], [15:8], [23:16], [31:24].
  - After byte 3, load the shift register from the next-word register.
  - On that load, ram_addr increments by 1.
  - The next-word register captures ram_data two cycles after the increment. That is always before it is needed, since at least 4 de cycles pass between loads.
  - de low: hold all state, no address change.
- Counters: pixel column x (0..WIDTH-1) and line y (0..HEIGHT-1) advance on de.
  - x wraps to 0 at WIDTH-1 and increments y.
  - After pixel (WIDTH-1, HEIGHT-1): frame_done pulses with the final grey_valid cycle + 1, and the state goes to DONE.
- DONE: de produces grey=0 and sets overrun. frame_start starts a new PREFETCH.
- pattern_en=1: grey = x[7:0]. Address and word sequencing proceed unchanged, so the frame stays aligned if the mode toggles mid-frame.
- Boundary cases:
  - frame_start in any state, including mid-ACTIVE: abort immediately, clear x, y, underrun and overrun, and restart PREFETCH.
  - frame_start and de in the same cycle: frame_start wins, and that de counts as an underrun.
  - de during PREFETCH: grey=0, grey_valid=1, underrun set. The pixel is not counted and PREFETCH is not extended.
  - ram_addr width: wraps modulo 2^ADDR_W, with no range check.
- Reset values:
  - ram_addr=BASE_ADDR, grey=0.
  - grey_valid=0, frame_done=0, underrun=0, overrun=0.
  - State IDLE, x=y=0.

## Timing
- grey and grey_valid are registered, with 1-cycle latency from de.
- frame_start must precede the first de by at least 5 cycles: the 4 PREFETCH cycles plus margin.
- ram_addr is registered. The RAM's registered read adds 1 cycle, so data is sampled 2 cycles after the address change.
- Words consumed per frame: WIDTH*HEIGHT/4. The final ram_addr is BASE_ADDR + WIDTH*HEIGHT/4 + 1, because of the one-word look-ahead.
- Flags:
  - frame_done: high for exactly 1 cycle.
  - underrun and overrun: change only on frame_start (clear) or on the offending de (set).
- Asserting reset mid-frame clears everything asynchronously. No output glitches on release.

## Test plan
- Reset: hold reset=0 with de toggling -> all outputs at reset values, ram_addr=0, grey_valid=0.
- Normal frame:
  - Setup: WIDTH=8, HEIGHT=2; RAM model word k = {4k+3, 4k+2, 4k+1, 4k}; frame_start, then de 16 consecutive cycles starting 6 cycles later.
  - Response: grey = 0..15 on consecutive cycles, each 1 cycle after de; frame_done pulses once, after grey=15; ram_addr ends at 5; no flags set.
- Line blanking:
  - Stimulus: same frame, with de low for 3 cycles after each 8 pixels and 1 random idle cycle mid-word.
  - Response: grey sequence still 0..15 with no repeats or skips.
- Overrun: a 17th de after frame_done -> grey=0, overrun=1. The next frame_start clears it and frame 2 outputs 0..15 again.
- Underrun / abort:
  - de 2 cycles after frame_start -> grey=0, underrun=1.
  - frame_start after 5 pixels of a frame -> next frame outputs starting at 0, underrun=0.
- Pattern mode: pattern_en=1 for pixels 4..7 -> grey = 0,1,2,3,4,5,6,7,8..15. The pixels 4..7 values come from x, and RAM data resumes at pixel 8 = 8.

Source files
------------

// File: rtl/frame_pixel_reader.sv
// frame_pixel_reader: frame RAM word prefetch and LSB-first grey pixel unpacking for the HDMI pixel stream.
module frame_pixel_reader #(
  parameter int WIDTH     = 640,
  parameter int HEIGHT    = 480,
  parameter int ADDR_W    = 17,
  parameter int BASE_ADDR = 0
) (
  input  logic              pixclk,
  input  logic              reset,
  input  logic              frame_start,
  input  logic              de,
  input  logic              pattern_en,
  output logic [ADDR_W-1:0] ram_addr,
  input  logic [31:0]       ram_data,
  output logic [7:0]        grey,
  output logic              grey_valid,
  output logic              frame_done,
  output logic              underrun,
  output logic              overrun
);
  localparam int XW = WIDTH > 1 ? $clog2(WIDTH) : 1;
  localparam int YW = HEIGHT > 1 ? $clog2(HEIGHT) : 1;
  localparam logic [1:0] IDLE = 2'd0, PREFETCH = 2'd1, ACTIVE = 2'd2, DONE = 2'd3;
  localparam logic [ADDR_W-1:0] BASE = ADDR_W'(BASE_ADDR);
  localparam logic [XW-1:0] XMAX = XW'(WIDTH - 1);
  localparam logic [YW-1:0] YMAX = YW'(HEIGHT - 1);

  logic [1:0]        state_q, state_d, pf_q, pf_d, byte_q, byte_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [31:0]       sh_q, sh_d, nxt_q, nxt_d;
  logic [XW-1:0]     x_q, x_d;
  logic [YW-1:0]     y_q, y_d;
  logic [2:0]        cap_q, cap_d;
  logic [7:0]        grey_q, grey_d;
  logic              gv_q, gv_d, last_q, last_d, fd_q, fd_d, un_q, un_d, ov_q, ov_d;

  always_comb begin
    state_d = state_q;
    pf_d    = pf_q;
    byte_d  = byte_q;
    addr_d  = addr_q;
    sh_d    = sh_q;
    nxt_d   = nxt_q;
    x_d     = x_q;
    y_d     = y_q;
    cap_d   = {cap_q[1:0], 1'b0};
    grey_d  = 8'h00;
    gv_d    = de;
    last_d  = 1'b0;
    fd_d    = last_q;
    un_d    = un_q;
    ov_d    = ov_q;
    // look-ahead word arrives three edges after its address was issued
    if (cap_q[2]) nxt_d = ram_data;
    if (frame_start) begin
      state_d = PREFETCH;
      pf_d    = 2'd0;
      byte_d  = 2'd0;
      addr_d  = BASE;
      x_d     = '0;
      y_d     = '0;
      cap_d   = 3'b000;
      un_d    = de;
      ov_d    = 1'b0;
    end else begin
      case (state_q)
        PREFETCH: begin
          pf_d = pf_q + 2'd1;
          if (pf_q == 2'd0) addr_d = BASE + ADDR_W'(1);
          if (pf_q == 2'd2) sh_d = ram_data;
          if (pf_q == 2'd3) begin
            nxt_d   = ram_data;
            state_d = ACTIVE;
          end
          if (de) un_d = 1'b1;
        end
        ACTIVE: if (de) begin
          grey_d = pattern_en ? 8'(x_q) : sh_q[8*byte_q +: 8];
          byte_d = byte_q + 2'd1;
          if (byte_q == 2'd3) begin
            sh_d     = nxt_q;
            addr_d   = addr_q + ADDR_W'(1);
            cap_d[0] = 1'b1;
          end
          x_d = x_q == XMAX ? '0 : x_q + 1'b1;
          if (x_q == XMAX) begin
            y_d = y_q + 1'b1;
            if (y_q == YMAX) begin
              y_d     = '0;
              state_d = DONE;
              last_d  = 1'b1;
            end
          end
        end
        DONE: if (de) ov_d = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge pixclk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      pf_q    <= 2'd0;
      byte_q  <= 2'd0;
      addr_q  <= BASE;
      sh_q    <= 32'h0;
      nxt_q   <= 32'h0;
      x_q     <= '0;
      y_q     <= '0;
      cap_q   <= 3'b000;
      grey_q  <= 8'h00;
      gv_q    <= 1'b0;
      last_q  <= 1'b0;
      fd_q    <= 1'b0;
      un_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      pf_q    <= pf_d;
      byte_q  <= byte_d;
      addr_q  <= addr_d;
      sh_q    <= sh_d;
      nxt_q   <= nxt_d;
      x_q     <= x_d;
      y_q     <= y_d;
      cap_q   <= cap_d;
      grey_q  <= grey_d;
      gv_q    <= gv_d;
      last_q  <= last_d;
      fd_q    <= fd_d;
      un_q    <= un_d;
      ov_q    <= ov_d;
    end
  end

  assign ram_addr   = addr_q;
  assign grey       = grey_q;
  assign grey_valid = gv_q;
  assign frame_done = fd_q;
  assign underrun   = un_q;
  assign overrun    = ov_q;
endmodule

// File: tb/tb_frame_pixel_reader.sv
// tb_frame_pixel_reader: scoreboard bench for frame_pixel_reader on an 8x2 frame with a registered-read RAM model.
module tb_frame_pixel_reader;
  logic        pixclk = 1'b0, reset = 1'b0, frame_start = 1'b0, de = 1'b0, pattern_en = 1'b0;
  logic [16:0] ram_addr, addr_r = '0;
  logic [31:0] ram_data = '0;
  logic [7:0]  grey, prev_grey = '0;
  logic        grey_valid, frame_done, underrun, overrun, de_s = 1'b0, prev_gv = 1'b0;
  logic [7:0]  exp_q[$];
  int          checks = 0, errors = 0, fd_cnt = 0;

  frame_pixel_reader #(.WIDTH(8), .HEIGHT(2), .ADDR_W(17), .BASE_ADDR(0)) dut (
    .pixclk(pixclk), .reset(reset), .frame_start(frame_start), .de(de), .pattern_en(pattern_en),
    .ram_addr(ram_addr), .ram_data(ram_data), .grey(grey), .grey_valid(grey_valid),
    .frame_done(frame_done), .underrun(underrun), .overrun(overrun)
  );

  always #5 pixclk = ~pixclk;

  function automatic logic [31:0] word(input logic [16:0] k);
    logic [7:0] b;
    b = {k[5:0], 2'b00};
    return {b + 8'd3, b + 8'd2, b + 8'd1, b};
  endfunction

  always @(posedge pixclk) begin
    addr_r   <= ram_addr;
    ram_data <= word(addr_r);
    de_s     <= de;
  end

  always @(negedge pixclk) if (reset) begin
    logic [7:0] e;
    checks++;
    if (grey_valid !== de_s) begin
      errors++;
      $display("FAIL valid_latency got %b exp %b", grey_valid, de_s);
    end
    if (grey_valid) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_pixel got %0d exp none", grey);
      end else begin
        e = exp_q.pop_front();
        if (grey !== e) begin
          errors++;
          $display("FAIL pixel got %0d exp %0d", grey, e);
        end
      end
    end
    if (frame_done) begin
      fd_cnt++;
      checks++;
      if (!(prev_gv && prev_grey == 8'd15)) begin
        errors++;
        $display("FAIL frame_done_timing got prev_valid %b prev_grey %0d exp 1 15", prev_gv, prev_grey);
      end
    end
    prev_gv   = grey_valid;
    prev_grey = grey;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge pixclk);
    #1;
  endtask

  task automatic px(input logic [7:0] e, input logic pe);
    de = 1'b1;
    pattern_en = pe;
    exp_q.push_back(e);
    tick(1);
    de = 1'b0;
    pattern_en = 1'b0;
  endtask

  task automatic start();
    frame_start = 1'b1;
    tick(1);
    frame_start = 1'b0;
  endtask

  task automatic frame();
    start();
    tick(5);
    for (int i = 0; i < 16; i++) px(8'(i), 1'b0);
    tick(4);
  endtask

  task automatic test_reset();
    for (int i = 0; i < 4; i++) begin
      de = i[0];
      tick(1);
    end
    de = 1'b0;
    checks += 6;
    if (grey_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", grey_valid); end
    if (grey !== 8'h00) begin errors++; $display("FAIL rst_grey got %0d exp 0", grey); end
    if (ram_addr !== 17'd0) begin errors++; $display("FAIL rst_addr got %0d exp 0", ram_addr); end
    if (frame_done !== 1'b0) begin errors++; $display("FAIL rst_done got %b exp 0", frame_done); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun got %b exp 0", underrun); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL rst_overrun got %b exp 0", overrun); end
    tick(1);
    reset = 1'b1;
    tick(2);
  endtask

  task automatic test_idle_de();
    px(8'd0, 1'b0);
    tick(2);
    checks += 3;
    if (underrun !== 1'b0) begin errors++; $display("FAIL idle_underrun got %b exp 0", underrun); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL idle_overrun got %b exp 0", overrun); end
    if (ram_addr !== 17'd0) begin errors++; $display("FAIL idle_addr got %0d exp 0", ram_addr); end
  endtask

  task automatic end_checks(input string name, input int fd0, input logic un);
    checks += 5;
    if (exp_q.size() != 0) begin errors++; $display("FAIL %s_drain got %0d left exp 0", name, exp_q.size()); exp_q.delete(); end
    if (fd_cnt - fd0 != 1) begin errors++; $display("FAIL %s_done_count got %0d exp 1", name, fd_cnt - fd0); end
    if (ram_addr !== 17'd5) begin errors++; $display("FAIL %s_addr got %0d exp 5", name, ram_addr); end
    if (underrun !== un) begin errors++; $display("FAIL %s_underrun got %b exp %b", name, underrun, un); end
    if (overrun !== 1'b0) begin errors++; $display("FAIL %s_overrun got %b exp 0", name, overrun); end
  endtask

  task automatic test_normal();
    int fd0 = fd_cnt;
    frame();
    end_checks("normal", fd0, 1'b0);
  endtask

  task automatic test_blanking();
    int fd0 = fd_cnt;
    int p = 4 * $urandom_range(0, 3) + $urandom_range(0, 2);
    start();
    tick(5);
    for (int i = 0; i < 16; i++) begin
      px(8'(i), 1'b0);
      if (i == p) tick(1);
      if (i % 8 == 7) tick(3);
    end
    tick(2);
    end_checks("blank", fd0, 1'b0);
  endtask

  task automatic test_overrun();
    int fd0;
    px(8'd0, 1'b0);
    checks += 2;
    if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_set got %b exp 1", overrun); end
    if (underrun !== 1'b0) begin errors++; $display("FAIL overrun_underrun got %b exp 0", underrun); end
    tick(2);
    fd0 = fd_cnt;
    start();
    checks++;
    if (overrun !== 1'b0) begin errors++; $display("FAIL overrun_clear got %b exp 0", overrun); end
    tick(5);
    for (int i = 0; i < 16; i++) px(8'(i), 1'b0);
    tick(4);
    end_checks("frame2", fd0, 1'b0);
  endtask

  task automatic test_underrun_abort();
    int fd0 = fd_cnt;
    start();
    tick(1);
    px(8'd0, 1'b0);
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL underrun_set got %b exp 1", underrun); end
    tick(2);
    for (int i = 0; i < 5; i++) px(8'(i), 1'b0);
    tick(2);
    start();
    checks++;
    if (underrun !== 1'b0) begin errors++; $display("FAIL abort_clear got %b exp 0", underrun); end
    tick(5);
    for (int i = 0; i < 16; i++) px(8'(i), 1'b0);
    tick(4);
    end_checks("abort", fd0, 1'b0);
  endtask

  task automatic test_collision();
    int fd0 = fd_cnt;
    frame_start = 1'b1;
    px(8'd0, 1'b0);
    frame_start = 1'b0;
    checks++;
    if (underrun !== 1'b1) begin errors++; $display("FAIL collide_underrun got %b exp 1", underrun); end
    tick(5);
    for (int i = 0; i < 16; i++) px(8'(i), 1'b0);
    tick(4);
    end_checks("collide", fd0, 1'b1);
  endtask

  task automatic test_pattern();
    int fd0 = fd_cnt;
    start();
    tick(5);
    for (int i = 0; i < 16; i++) px(8'(i), i >= 4 && i < 8);
    tick(4);
    end_checks("pattern", fd0, 1'b0);
  endtask

  task automatic test_async_reset();
    int fd0;
    start();
    tick(5);
    for (int i = 0; i < 5; i++) px(8'(i), 1'b0);
    tick(2);
    checks++;
    if (ram_addr !== 17'd2) begin errors++; $display("FAIL midframe_addr got %0d exp 2", ram_addr); end
    #2 reset = 1'b0;
    #1;
    checks += 2;
    if (ram_addr !== 17'd0) begin errors++; $display("FAIL async_addr got %0d exp 0", ram_addr); end
    if (grey_valid !== 1'b0) begin errors++; $display("FAIL async_valid got %b exp 0", grey_valid); end
    tick(2);
    reset = 1'b1;
    tick(2);
    fd0 = fd_cnt;
    frame();
    end_checks("post_reset", fd0, 1'b0);
  endtask

  initial begin
    test_reset();
    test_idle_de();
    test_normal();
    test_blanking();
    test_overrun();
    test_underrun_abort();
    test_collision();
    test_pattern();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
